// File: rtl/inv_lift_53_pkg.sv
// Shared types for the inverse 5/3 lifting stage.
// Define INV_LIFT_SAT_EN to saturate out_data; otherwise it wraps to W bits.
package inv_lift_pkg;

  localparam int unsigned W     = 8;
  localparam int unsigned GUARD = 2;
  localparam int unsigned IW    = W + GUARD;

  typedef logic signed [W-1:0]  sample_t;
  typedef logic signed [IW-1:0] wide_t;

  typedef enum logic [1:0] {StWait, StOdd, StEven, StTail} state_e;

`ifdef INV_LIFT_SAT_EN
  localparam wide_t SatHi = wide_t'((1 << (W - 1)) - 1);
  localparam wide_t SatLo = wide_t'(-(1 << (W - 1)));
`endif

  // Narrow an internal W+2 bit value to the output sample width.
  function automatic sample_t reduce(wide_t v);
    sample_t r;
`ifdef INV_LIFT_SAT_EN
    if (v > SatHi) begin
      r = sample_t'(SatHi);
    end else if (v < SatLo) begin
      r = sample_t'(SatLo);
    end else begin
      r = sample_t'(v);
    end
`else
    r = sample_t'(v);
`endif
    return r;
  endfunction

endpackage

// File: rtl/inv_lift_53_if.sv
// Coefficient-pair input stream and reconstructed-sample output stream.
interface inv_lift_53_if;
  import inv_lift_pkg::*;

  sample_t in_s;
  sample_t in_d;
  logic    in_last;
  logic    in_valid;
  logic    in_ready;
  sample_t out_data;
  logic    out_last;
  logic    out_valid;
  logic    out_ready;

  modport master (
    output in_s, in_d, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );

  modport slave (
    input  in_s, in_d, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_valid
  );

endinterface

// File: rtl/inv_lift_53_lift_step.sv
// Combinational 5/3 inverse lifting: even update and odd predict at W+2 bits.
module lift_step
  import inv_lift_pkg::*;
(
  input  sample_t s,
  input  sample_t d,
  input  logic    first,
  input  wide_t   d_prev,
  input  wide_t   e_prev,
  output wide_t   e_cur,
  output wide_t   x_odd,
  output wide_t   x_tail
);

  wide_t s_w;
  wide_t d_w;
  wide_t d_left;
  wide_t upd;

  always_comb begin
    s_w    = wide_t'(s);
    d_w    = wide_t'(d);
    // Frame start mirrors d[-1] onto d[0].
    d_left = first ? d_w : d_prev;
    upd    = (d_left + d_w + wide_t'(2)) >>> 2;
    e_cur  = s_w - upd;
    x_odd  = d_prev + ((e_prev + e_cur) >>> 1);
    x_tail = d_prev + e_prev;
  end

endmodule

// File: rtl/inv_lift_53.sv
// Inverse 5/3 lifting IDWT: one (s,d) pair in, two natural-order samples out.
// Output reduction is saturating when INV_LIFT_SAT_EN is defined, wrapping otherwise.
module inv_lift_53
  import inv_lift_pkg::*;
(
  input logic           clk,
  input logic           rst,
  inv_lift_53_if.slave  bus
);

  state_e  state_q, state_d;
  wide_t   d_prev_q, e_prev_q;
  logic    first_q, last_q;
  sample_t out_data_q;
  logic    out_last_q, out_valid_q;

  logic    ready;
  logic    accept;
  wide_t   e_cur, x_odd, x_tail;

  lift_step u_lift_step (
    .s      (bus.in_s),
    .d      (bus.in_d),
    .first  (first_q),
    .d_prev (d_prev_q),
    .e_prev (e_prev_q),
    .e_cur  (e_cur),
    .x_odd  (x_odd),
    .x_tail (x_tail)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StWait;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait: if (accept) state_d = first_q ? StEven : StOdd;
      StOdd:  if (bus.out_ready) state_d = StEven;
      StEven: begin
        if (bus.out_ready) begin
          if (last_q)      state_d = StTail;
          else if (accept) state_d = StOdd;
          else             state_d = StWait;
        end
      end
      StTail: if (bus.out_ready) state_d = StWait;
      default: state_d = StWait;
    endcase
  end

  // Gating with rst keeps in_ready low while reset is held.
  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      StWait:  ready = 1'b1;
      StEven:  ready = bus.out_ready & ~last_q;
      default: ready = 1'b0;
    endcase
    ready  = ready & rst;
    accept = ready & bus.in_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_prev_q    <= '0;
      e_prev_q    <= '0;
      first_q     <= 1'b1;
      last_q      <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      // e[k] is kept in e_prev for the EVEN beat that follows ODD.
      d_prev_q    <= wide_t'(bus.in_d);
      e_prev_q    <= e_cur;
      last_q      <= bus.in_last;
      first_q     <= 1'b0;
      out_data_q  <= first_q ? reduce(e_cur) : reduce(x_odd);
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      unique case (state_q)
        StOdd: out_data_q <= reduce(e_prev_q);
        StEven: begin
          if (last_q) begin
            out_data_q <= reduce(x_tail);
            out_last_q <= 1'b1;
          end else begin
            out_valid_q <= 1'b0;
          end
        end
        StTail: begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          first_q     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_inv_lift_53.sv
// Randomized self-checking bench for inv_lift_53 against a frame-level 5/3 model.
module tb_inv_lift_53;
  import inv_lift_pkg::*;

  logic clk;
  logic rst;
  inv_lift_53_if bus ();

  inv_lift_53 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int fs[$];
  int fd[$];
  bit fl[$];
  int exp_d[$];
  bit exp_l[$];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int reduce_ref(input int v);
    int r;
`ifdef INV_LIFT_SAT_EN
    r = (v > 127) ? 127 : ((v < -128) ? -128 : v);
`else
    r = v & 255;
    if (r >= 128) r -= 256;
`endif
    return r;
  endfunction

  task automatic push_pair(input int s, input int d, input bit l);
    fs.push_back(s);
    fd.push_back(d);
    fl.push_back(l);
  endtask

  task automatic push_exp(input int v, input bit l);
    exp_d.push_back(v);
    exp_l.push_back(l);
  endtask

  // Inverse transform of a whole frame from its coefficient lists.
  task automatic add_frame(input int s[$], input int d[$]);
    int kn;
    int e[$];
    kn = s.size();
    for (int k = 0; k < kn; k++) push_pair(s[k], d[k], k == kn - 1);
    for (int k = 0; k < kn; k++) begin
      int dl;
      dl = (k == 0) ? d[0] : d[k-1];
      e.push_back(s[k] - ((dl + d[k] + 2) >>> 2));
    end
    for (int k = 0; k < kn; k++) begin
      push_exp(reduce_ref(e[k]), 1'b0);
      if (k < kn - 1) push_exp(reduce_ref(d[k] + ((e[k] + e[k+1]) >>> 1)), 1'b0);
      else            push_exp(reduce_ref(d[k] + e[k]), 1'b1);
    end
  endtask

  // Forward-transform x and expect x back unchanged.
  task automatic add_roundtrip(input int x[$]);
    int kn;
    int d[$];
    kn = x.size() / 2;
    for (int k = 0; k < kn; k++) begin
      int xr;
      xr = (k == kn - 1) ? x[2*k] : x[2*k+2];
      d.push_back(x[2*k+1] - ((x[2*k] + xr) >>> 1));
    end
    for (int k = 0; k < kn; k++) begin
      int dl;
      dl = (k == 0) ? d[0] : d[k-1];
      push_pair(x[2*k] + ((dl + d[k] + 2) >>> 2), d[k], k == kn - 1);
    end
    for (int n = 0; n < 2 * kn; n++) push_exp(x[n], n == 2 * kn - 1);
  endtask

  task automatic load_vector();
    int vx[8];
    int vs[4];
    int vd[4];
    vx = '{10, 40, 20, 50, 30, 60, 28, 46};
    vs = '{23, 33, 44, 40};
    vd = '{25, 25, 31, 18};
    for (int k = 0; k < 4; k++) push_pair(vs[k], vd[k], k == 3);
    for (int n = 0; n < 8; n++) push_exp(vx[n], n == 7);
  endtask

  task automatic run_stream(input int ready_pct, input int abort_after, output int gaps);
    int idx, popped, cyc, held_d, held_l;
    bit in_frame, stalled;
    idx = 0; popped = 0; cyc = 0; held_d = 0; held_l = 0;
    in_frame = 1'b0; stalled = 1'b0; gaps = 0;
    while (1) begin
      @(posedge clk); #1;
      if (idx < fs.size()) begin
        bus.in_s     = sample_t'(fs[idx]);
        bus.in_d     = sample_t'(fd[idx]);
        bus.in_last  = fl[idx];
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      cyc++;
      if (bus.in_valid && bus.in_ready) idx++;
      if (stalled) begin
        check("hold_valid", int'(bus.out_valid), 1);
        check("hold_data", int'(bus.out_data), held_d);
        check("hold_last", int'(bus.out_last), held_l);
      end
      stalled = 1'b0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (exp_d.size() == 0) begin
            check("extra_sample", int'(bus.out_valid), 0);
          end else begin
            check("data", int'(bus.out_data), exp_d[0]);
            check("last", int'(bus.out_last), int'(exp_l[0]));
            in_frame = !exp_l[0];
            void'(exp_d.pop_front());
            void'(exp_l.pop_front());
            popped++;
          end
        end else begin
          stalled = 1'b1;
          held_d  = int'(bus.out_data);
          held_l  = int'(bus.out_last);
        end
      end else if (in_frame && bus.out_ready) begin
        gaps++;
      end
      if (abort_after > 0 && popped >= abort_after) break;
      if (idx >= fs.size() && exp_d.size() == 0) break;
      if (cyc >= 3000) begin
        check("timeout_remaining", exp_d.size(), 0);
        break;
      end
    end
    if (abort_after == 0) check("pairs_sent", idx, fs.size());
    fs.delete(); fd.delete(); fl.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion",
             n_tests);
    $fatal(1);
  end

  initial begin
    int gaps;
    int s[$];
    int d[$];
    int x[$];
    bus.in_s = '0; bus.in_d = '0; bus.in_last = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", int'(bus.in_ready), 0);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_data", int'(bus.out_data), 0);
      check("rst_out_last", int'(bus.out_last), 0);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", int'(bus.in_ready), 1);

    load_vector();
    run_stream(100, 0, gaps);
    check("gaps_vector", gaps, 0);

    push_pair(127, -128, 1'b1);
`ifdef INV_LIFT_SAT_EN
    push_exp(127, 1'b0);
`else
    push_exp(-65, 1'b0);
`endif
    push_exp(63, 1'b1);
    run_stream(100, 0, gaps);

    load_vector();
    run_stream(50, 0, gaps);

    load_vector();
    load_vector();
    run_stream(100, 0, gaps);
    check("gaps_b2b", gaps, 0);

    for (int f = 0; f < 15; f++) begin
      int kn;
      kn = int'($urandom_range(6, 1));
      s.delete(); d.delete();
      for (int k = 0; k < kn; k++) begin
        s.push_back(int'($urandom_range(255)) - 128);
        d.push_back(int'($urandom_range(255)) - 128);
      end
      add_frame(s, d);
    end
    run_stream(70, 0, gaps);

    for (int f = 0; f < 8; f++) begin
      int kn;
      kn = int'($urandom_range(5, 1));
      x.delete();
      for (int n = 0; n < 2 * kn; n++) x.push_back(int'($urandom_range(120)) - 60);
      add_roundtrip(x);
    end
    run_stream(60, 0, gaps);

    load_vector();
    run_stream(100, 3, gaps);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    exp_d.delete(); exp_l.delete();
    repeat (2) begin
      @(negedge clk);
      check("midrst_out_valid", int'(bus.out_valid), 0);
      check("midrst_in_ready", int'(bus.in_ready), 0);
    end
    @(posedge clk); #1 rst = 1'b1;
    load_vector();
    run_stream(100, 0, gaps);
    check("gaps_after_rst", gaps, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
